ddram_loader: RTL and testbench
===============================

DDRAM_LOADER -- requirements
Module: ddram_loader

Interface
REQ-001 Parameter BASE, default 28'h0000000, SHALL be the byte offset added to ioctl_addr to form wraddr.
REQ-002 Parameter DEPTH, default 4, SHALL be the word-FIFO depth, a power of two no smaller than 2.
REQ-003 Parameter SWAP, default 0, SHALL place the odd byte in din[7:0] when set to 1.
REQ-004 DDRAM_CLK  in  1  SHALL be the single clock for all logic.
REQ-005 RESET_N  in  1  SHALL be a synchronous, active-low reset.
REQ-006 ioctl_download  in  1  SHALL be high for the duration of a download.
REQ-007 ioctl_wr  in  1  SHALL be a one-cycle strobe marking ioctl_dout as valid.
REQ-008 ioctl_addr  in  27  SHALL carry the byte address within the download.
REQ-009 ioctl_dout  in  8  SHALL carry the download byte.
REQ-010 ioctl_wait  out  1  SHALL request the host to hold its next strobe.
REQ-011 wraddr  out  28  SHALL drive the write byte address, with bit0 always 0.
REQ-012 din  out  16  SHALL drive the write data word.
REQ-013 we_req  out  1  SHALL be the toggle write request.
REQ-014 we_ack  in  1  SHALL be the toggle write acknowledge from the DDR arbiter.
REQ-015 done  out  1  SHALL pulse for one cycle when a download has been fully committed to DDR.

Function
REQ-016 On an even-address strobe, the block SHALL latch the byte into the pack register and set pend.
REQ-017 On an odd-address strobe with pend set and a matching addr[26:1], the block SHALL push {BASE+{addr[26:1],1'b0}, word} to the FIFO and clear pend.
REQ-018 An odd strobe without a matching pend SHALL push a word whose missing byte is 8'hFF.
REQ-019 An even strobe while pend is set SHALL first flush the old pending byte with 8'hFF padding, then latch the new byte.
REQ-020 The falling edge of ioctl_download with pend set SHALL flush the pending byte with 8'hFF padding.
REQ-021 Default byte order SHALL be din = {odd, even}; SWAP=1 SHALL reverse it.
REQ-022 Address arithmetic SHALL be 28-bit modulo 2^28, with no saturation.
REQ-023 ioctl_wait SHALL be high whenever FIFO occupancy is at least DEPTH-1, so that a flush plus push in one cycle never overflows.
REQ-024 A strobe arriving while the FIFO is full is a protocol violation; the block SHALL drop the word and set a sticky overflow bit, readable only in simulation.
REQ-025 The write FSM SHALL have these states: IDLE -> ISSUE when the FIFO is non-empty; ISSUE -> WAIT; WAIT -> IDLE when we_ack == we_req.
REQ-026 In ISSUE, the FSM SHALL pop the FIFO head into the wraddr/din registers and toggle we_req in the same cycle.
REQ-027 wraddr and din SHALL remain stable from ISSUE until the ack is seen.
REQ-028 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-029 Minimum latency SHALL be: odd strobe at cycle N -> we_req toggles at N+2.
REQ-030 Throughput SHALL be one word per three cycles plus the ack delay.
REQ-031 done SHALL pulse one cycle after ioctl_download is low, pend is 0, the FIFO is empty and the FSM is IDLE with the ack matched, and only once per download.
REQ-032 A strobe while ioctl_download is low SHALL be ignored.

Reset
REQ-033 While RESET_N is low, the block SHALL set: we_req=0, wraddr=0, din=0, ioctl_wait=0, done=0, pend=0, FIFO empty, FSM IDLE, overflow=0.
REQ-034 Reset asserted mid-handshake SHALL abandon the pending write, and we_req SHALL return to 0.
REQ-035 After a mid-handshake reset, the DDR arbiter SHALL be reset in the same cycle so that we_ack also returns to 0.

Structure
REQ-036 Package ddram_pkg SHALL hold the FSM state enum (IDLE, ISSUE, WAIT), the word-entry struct {addr[27:0], data[15:0]} and PAD_BYTE=8'hFF.
REQ-037 The FIFO SHALL be a sub-module loader_fifo, with DEPTH entries, a registered count, and full/empty/almost_full outputs.
REQ-038 Packing and the write FSM SHALL remain in ddram_loader.

Verification
REQ-039 A reset-then-idle check SHALL confirm: RESET_N low 2 cycles -> all outputs 0, no we_req toggle for 50 cycles.
REQ-040 A byte-pair check SHALL confirm: download bytes 0x12@0, 0x34@1 with BASE=28'h0100000 -> one toggle, wraddr=28'h0100000, din=16'h3412.
REQ-041 An odd-length check SHALL confirm: bytes 0xAA@0, 0xBB@1, 0xCC@2, then download falls -> writes 16'hBBAA@0 and 16'h FFCC@2, then done pulses once.
REQ-042 A backpressure check SHALL confirm: we_ack held for 40 cycles while strobes stream every 4 cycles -> ioctl_wait rises at occupancy 3 (DEPTH=4), no overflow, writes in address order.
REQ-043 A reset-mid-handshake check SHALL confirm: reset in WAIT -> we_req=0 next cycle, FIFO empty, and a new download writes correctly.
REQ-044 A SWAP check SHALL confirm: SWAP=1, bytes 0x12@0, 0x34@1 -> din=16'h1234.

Source files
------------

// File: rtl/ddram_pkg.sv
// Shared types and helpers for the DDRAM download loader: FSM states, FIFO word entry,
// pad byte, byte packing and word-address formation.
package ddram_pkg;

  typedef enum logic [1:0] {
    Idle,
    Issue,
    Wait
  } state_e;

  typedef struct packed {
    logic [27:0] addr;
    logic [15:0] data;
  } word_t;

  localparam logic [7:0] PAD_BYTE = 8'hFF;

  function automatic logic [15:0] pack_word(input logic swap, input logic [7:0] even_b,
                                            input logic [7:0] odd_b);
    return swap ? {even_b, odd_b} : {odd_b, even_b};
  endfunction

  // Modulo-2^28 byte address of a 16-bit word; bit0 forced low even for an odd BASE.
  function automatic logic [27:0] word_addr(input logic [27:0] base, input logic [25:0] widx);
    logic [27:0] sum;
    sum = base + {1'b0, widx, 1'b0};
    return {sum[27:1], 1'b0};
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Word FIFO between the byte packer and the DDR write FSM. Accepts up to two pushes per cycle
// (flush of a stale pending byte followed by a new word) and one pop.
module loader_fifo
  import ddram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_push_a,
  input  word_t i_word_a,
  input  logic  i_push_b,
  input  word_t i_word_b,
  input  logic  i_pop,
  output word_t o_head,
  output logic  o_empty,
  output logic  o_full,
  output logic  o_almost_full,
  output logic  o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  word_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  logic           w_acc_a;
  logic           w_acc_b;
  logic           w_pop;
  logic [CW-1:0]  w_count_a;

  // Port b only sees the room left after port a; pushes into a full FIFO are dropped.
  always_comb begin
    w_acc_a   = i_push_a && (r_count < FullCount);
    w_count_a = r_count + CW'(w_acc_a);
    w_acc_b   = i_push_b && (w_count_a < FullCount);
    w_pop     = i_pop && (r_count != '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_acc_a) + AW'(w_acc_b);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_a + CW'(w_acc_b) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_acc_a) begin
      r_mem[r_wptr] <= i_word_a;
    end
    if (w_acc_b) begin
      r_mem[r_wptr + AW'(w_acc_a)] <= i_word_b;
    end
  end

  assign o_head        = r_mem[r_rptr];
  assign o_empty       = (r_count == '0);
  assign o_full        = (r_count == FullCount);
  assign o_almost_full = (r_count >= FullCount - CW'(1));
  assign o_drop        = (i_push_a && !w_acc_a) || (i_push_b && !w_acc_b);

endmodule

// File: rtl/ddram_loader.sv
// Packs an ioctl byte-stream download into 16-bit words and writes them to DDR through a
// toggle req/ack handshake, padding unpaired bytes with PAD_BYTE.
module ddram_loader
  import ddram_pkg::*;
#(
  parameter logic [27:0] BASE  = 28'h0000000,
  parameter int unsigned DEPTH = 4,
  parameter bit          SWAP  = 1'b0
) (
  input  logic        DDRAM_CLK,
  input  logic        RESET_N,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [27:0] wraddr,
  output logic [15:0] din,
  output logic        we_req,
  input  logic        we_ack,
  output logic        done
);

  logic        r_pend;
  logic [25:0] r_pend_idx;
  logic [7:0]  r_pend_byte;
  logic        r_dl;
  logic        r_armed;
  logic        r_overflow;
  state_e      r_state;
  logic        r_we_req;
  logic [27:0] r_wraddr;
  logic [15:0] r_din;
  logic        r_done;

  logic  w_strobe;
  logic  w_fall;
  logic  w_match;
  logic  w_push_a;
  logic  w_push_b;
  word_t w_word_a;
  word_t w_word_b;
  word_t w_flush_word;
  word_t w_pair_word;
  word_t w_lone_word;
  word_t w_head;
  logic  w_empty;
  logic  w_full;
  logic  w_almost_full;
  logic  w_drop;
  logic  w_pop;

  assign w_strobe = ioctl_wr && ioctl_download;
  assign w_fall   = r_dl && !ioctl_download;
  assign w_match  = r_pend && (r_pend_idx == ioctl_addr[26:1]);
  assign w_pop    = (r_state == Issue);

  assign w_flush_word = {word_addr(BASE, r_pend_idx), pack_word(SWAP, r_pend_byte, PAD_BYTE)};
  assign w_pair_word  = {word_addr(BASE, ioctl_addr[26:1]),
                         pack_word(SWAP, r_pend_byte, ioctl_dout)};
  assign w_lone_word  = {word_addr(BASE, ioctl_addr[26:1]),
                         pack_word(SWAP, PAD_BYTE, ioctl_dout)};

  // A stale pending byte always goes out on port a ahead of any word from the current strobe.
  always_comb begin
    w_push_a = 1'b0;
    w_push_b = 1'b0;
    w_word_a = '0;
    w_word_b = '0;
    if (w_strobe) begin
      if (!ioctl_addr[0]) begin
        w_push_a = r_pend;
        w_word_a = w_flush_word;
      end else if (w_match) begin
        w_push_a = 1'b1;
        w_word_a = w_pair_word;
      end else if (r_pend) begin
        w_push_a = 1'b1;
        w_word_a = w_flush_word;
        w_push_b = 1'b1;
        w_word_b = w_lone_word;
      end else begin
        w_push_a = 1'b1;
        w_word_a = w_lone_word;
      end
    end else if (w_fall && r_pend) begin
      w_push_a = 1'b1;
      w_word_a = w_flush_word;
    end
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (!RESET_N) begin
      r_pend      <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_byte <= '0;
      r_dl        <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_dl <= ioctl_download;
      if (w_strobe) begin
        if (!ioctl_addr[0]) begin
          r_pend      <= 1'b1;
          r_pend_idx  <= ioctl_addr[26:1];
          r_pend_byte <= ioctl_dout;
        end else begin
          r_pend <= 1'b0;
        end
      end else if (w_fall) begin
        r_pend <= 1'b0;
      end
      r_overflow <= r_overflow | w_drop;
    end
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (!RESET_N) begin
      r_state  <= Idle;
      r_we_req <= 1'b0;
      r_wraddr <= '0;
      r_din    <= '0;
      r_done   <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ioctl_download) begin
        r_armed <= 1'b1;
      end else if (r_armed && !r_pend && w_empty && (r_state == Idle) && (we_ack == r_we_req)) begin
        r_done  <= 1'b1;
        r_armed <= 1'b0;
      end
      case (r_state)
        Idle: begin
          if (!w_empty) begin
            r_state <= Issue;
          end
        end
        Issue: begin
          r_wraddr <= w_head.addr;
          r_din    <= w_head.data;
          r_we_req <= ~r_we_req;
          r_state  <= Wait;
        end
        Wait: begin
          if (we_ack == r_we_req) begin
            r_state <= Idle;
          end
        end
        default: r_state <= Idle;
      endcase
    end
  end

  loader_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk        (DDRAM_CLK),
    .i_rst_n      (RESET_N),
    .i_push_a     (w_push_a),
    .i_word_a     (w_word_a),
    .i_push_b     (w_push_b),
    .i_word_b     (w_word_b),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_almost_full(w_almost_full),
    .o_drop       (w_drop)
  );

  assign ioctl_wait = w_almost_full || w_full;
  assign wraddr     = r_wraddr;
  assign din        = r_din;
  assign we_req     = r_we_req;
  assign done       = r_done;

endmodule

// File: tb/tb_ddram_loader.sv
// Bench for ddram_loader: a SWAP=0 and a SWAP=1 instance share the ioctl stream; each has its
// own toggle-ack arbiter model, and writes are scored against an expected-word queue.
module tb_ddram_loader;

  localparam logic [27:0] Base = 28'h0100000;

  typedef struct {
    logic [27:0] addr;
    logic [15:0] data_m;
    logic [15:0] data_s;
  } exp_t;

  typedef struct {
    logic [27:0] addr;
    logic [15:0] data;
    int          cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dl = 1'b0;
  logic        wr = 1'b0;
  logic [26:0] addr = '0;
  logic [7:0]  dout = '0;
  logic        hold = 1'b0;
  logic        ack_m, ack_s;
  logic        wait_m, wait_s, req_m, req_s, done_m, done_s;
  logic [27:0] wa_m, wa_s;
  logic [15:0] din_m, din_s;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_m_cnt = 0;
  int   done_s_cnt = 0;
  logic prev_m = 1'b0;
  logic prev_s = 1'b0;
  logic rst_d = 1'b0;

  exp_t exp_q[$];
  obs_t obs_m[$];
  obs_t obs_s[$];
  exp_t e;
  obs_t om, os;

  always #5 clk = ~clk;

  ddram_loader #(.BASE(Base), .DEPTH(4), .SWAP(1'b0)) dut (
    .DDRAM_CLK(clk), .RESET_N(rst_n), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait_m), .wraddr(wa_m), .din(din_m),
    .we_req(req_m), .we_ack(ack_m), .done(done_m)
  );

  ddram_loader #(.BASE(Base), .DEPTH(4), .SWAP(1'b1)) dut_s (
    .DDRAM_CLK(clk), .RESET_N(rst_n), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait_s), .wraddr(wa_s), .din(din_s),
    .we_req(req_s), .we_ack(ack_s), .done(done_s)
  );

  // Arbiter models: ack follows req one cycle later, reset together with the loader.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      if (!hold && ack_m != req_m) ack_m <= req_m;
      if (ack_s != req_s) ack_s <= req_s;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rst_d && req_m !== prev_m) obs_m.push_back('{wa_m, din_m, cyc});
    if (rst_n && rst_d && req_s !== prev_s) obs_s.push_back('{wa_s, din_s, cyc});
    prev_m <= req_m;
    prev_s <= req_s;
    rst_d  <= rst_n;
    if (rst_n && done_m === 1'b1) done_m_cnt <= done_m_cnt + 1;
    if (rst_n && done_s === 1'b1) done_s_cnt <= done_s_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [27:0] off, input logic [7:0] ev, input logic [7:0] od);
    exp_q.push_back('{Base + off, {od, ev}, {ev, od}});
  endtask

  // Host side: honours ioctl_wait, then issues a one-cycle strobe; s = cycle it was sampled.
  task automatic put(input logic [26:0] a, input logic [7:0] d, output int s);
    int guard = 0;
    while (wait_m === 1'b1 && guard < 200) begin
      tick(1);
      guard++;
    end
    total++;
    if (wait_m !== 1'b0) begin
      bad++;
      $display("FAIL host_hold: ioctl_wait got %b want 0 before strobe @%h", wait_m, a);
    end
    addr = a;
    dout = d;
    wr   = 1'b1;
    tick(1);
    s  = cyc;
    wr = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int guard = 0;
    while ((obs_m.size() < n || obs_s.size() < n) && guard < 300) begin
      tick(1);
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    total += 6;
    if (req_m !== 1'b0) begin bad++; $display("FAIL rst_we_req: got %b want 0", req_m); end
    if (wa_m !== '0) begin bad++; $display("FAIL rst_wraddr: got %h want 0", wa_m); end
    if (din_m !== '0) begin bad++; $display("FAIL rst_din: got %h want 0", din_m); end
    if (wait_m !== 1'b0) begin bad++; $display("FAIL rst_wait: got %b want 0", wait_m); end
    if (done_m !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_m); end
    if (req_s !== 1'b0) begin bad++; $display("FAIL rst_we_req_swap: got %b want 0", req_s); end
    rst_n = 1'b1;
    tick(50);
    total += 3;
    if (obs_m.size() != 0 || obs_s.size() != 0) begin
      bad++;
      $display("FAIL idle_toggles: got %0d/%0d want 0", obs_m.size(), obs_s.size());
    end
    if (done_m_cnt != 0) begin bad++; $display("FAIL idle_done: got %0d want 0", done_m_cnt); end
    if (dut.r_overflow !== 1'b0) begin
      bad++;
      $display("FAIL rst_overflow: got %b want 0", dut.r_overflow);
    end
  endtask

  task automatic test_byte_pair();
    int s0, s1, d_m, d_s;
    d_m = done_m_cnt;
    d_s = done_s_cnt;
    dl = 1'b1;
    tick(1);
    put(27'h0, 8'h12, s0);
    put(27'h1, 8'h34, s1);
    expect_word(28'h0, 8'h12, 8'h34);
    dl = 1'b0;
    wait_writes(1);
    e = exp_q.pop_front();
    total += 3;
    if (obs_m.size() == 0 || obs_s.size() == 0) begin
      bad += 3;
      $display("FAIL pair: write missing got %0d/%0d want 1", obs_m.size(), obs_s.size());
    end else begin
      om = obs_m.pop_front();
      os = obs_s.pop_front();
      if (om.addr !== e.addr || om.data !== e.data_m) begin
        bad++;
        $display("FAIL pair_main: got %h/%h want %h/%h", om.addr, om.data, e.addr, e.data_m);
      end
      if (os.addr !== e.addr || os.data !== e.data_s) begin
        bad++;
        $display("FAIL pair_swap: got %h/%h want %h/%h", os.addr, os.data, e.addr, e.data_s);
      end
      if (om.cyc - s1 != 2) begin
        bad++;
        $display("FAIL pair_latency: got %0d want 2 cycles", om.cyc - s1);
      end
    end
    tick(10);
    total += 2;
    if (done_m_cnt - d_m != 1) begin
      bad++;
      $display("FAIL pair_done_main: got %0d pulses want 1", done_m_cnt - d_m);
    end
    if (done_s_cnt - d_s != 1) begin
      bad++;
      $display("FAIL pair_done_swap: got %0d pulses want 1", done_s_cnt - d_s);
    end
  endtask

  task automatic test_odd_length();
    int s, d_m;
    d_m = done_m_cnt;
    dl = 1'b1;
    put(27'h0, 8'hAA, s);
    put(27'h1, 8'hBB, s);
    put(27'h2, 8'hCC, s);
    expect_word(28'h0, 8'hAA, 8'hBB);
    expect_word(28'h2, 8'hCC, 8'hFF);
    tick(2);
    dl = 1'b0;
    wait_writes(2);
    repeat (2) begin
      e = exp_q.pop_front();
      total += 2;
      if (obs_m.size() == 0 || obs_s.size() == 0) begin
        bad += 2;
        $display("FAIL odd_len: write missing, want %h", e.addr);
      end else begin
        om = obs_m.pop_front();
        os = obs_s.pop_front();
        if (om.addr !== e.addr || om.data !== e.data_m) begin
          bad++;
          $display("FAIL odd_len_main: got %h/%h want %h/%h", om.addr, om.data, e.addr, e.data_m);
        end
        if (os.addr !== e.addr || os.data !== e.data_s) begin
          bad++;
          $display("FAIL odd_len_swap: got %h/%h want %h/%h", os.addr, os.data, e.addr, e.data_s);
        end
      end
    end
    tick(20);
    total += 2;
    if (done_m_cnt - d_m != 1) begin
      bad++;
      $display("FAIL odd_len_done: got %0d pulses want 1", done_m_cnt - d_m);
    end
    if (obs_m.size() != 0) begin
      bad++;
      $display("FAIL odd_len_extra: got %0d extra writes want 0", obs_m.size());
    end
  endtask

  task automatic test_orphans();
    int s;
    dl = 1'b1;
    put(27'h4, 8'h11, s);
    put(27'h6, 8'h22, s);
    put(27'h7, 8'h33, s);
    put(27'h9, 8'h44, s);
    put(27'hA, 8'h55, s);
    put(27'hD, 8'h66, s);
    expect_word(28'h4, 8'h11, 8'hFF);
    expect_word(28'h6, 8'h22, 8'h33);
    expect_word(28'h8, 8'hFF, 8'h44);
    expect_word(28'hA, 8'h55, 8'hFF);
    expect_word(28'hC, 8'hFF, 8'h66);
    dl = 1'b0;
    wait_writes(5);
    repeat (5) begin
      e = exp_q.pop_front();
      total += 2;
      if (obs_m.size() == 0 || obs_s.size() == 0) begin
        bad += 2;
        $display("FAIL orphan: write missing, want %h", e.addr);
      end else begin
        om = obs_m.pop_front();
        os = obs_s.pop_front();
        if (om.addr !== e.addr || om.data !== e.data_m) begin
          bad++;
          $display("FAIL orphan_main: got %h/%h want %h/%h", om.addr, om.data, e.addr, e.data_m);
        end
        if (os.addr !== e.addr || os.data !== e.data_s) begin
          bad++;
          $display("FAIL orphan_swap: got %h/%h want %h/%h", os.addr, os.data, e.addr, e.data_s);
        end
      end
    end
    total++;
    if (dut.r_overflow !== 1'b0 || dut_s.r_overflow !== 1'b0) begin
      bad++;
      $display("FAIL orphan_overflow: got %b/%b want 0/0", dut.r_overflow, dut_s.r_overflow);
    end
    tick(10);
  endtask

  task automatic test_backpressure();
    int s, start;
    logic want_wait;
    hold  = 1'b1;
    start = cyc;
    dl    = 1'b1;
    for (int w = 0; w < 6; w++) begin
      if (w == 4) begin
        while (cyc - start < 40) tick(1);
        total += 4;
        if (wait_m !== 1'b1) begin bad++; $display("FAIL bp_wait_held: got %b want 1", wait_m); end
        if (obs_m.size() != 1) begin
          bad++;
          $display("FAIL bp_issued: got %0d writes want 1 while ack held", obs_m.size());
        end
        if (wa_m !== Base + 28'h20) begin
          bad++;
          $display("FAIL bp_stable: wraddr got %h want %h", wa_m, Base + 28'h20);
        end
        if (dut.r_overflow !== 1'b0) begin
          bad++;
          $display("FAIL bp_overflow: got %b want 0", dut.r_overflow);
        end
        hold = 1'b0;
      end
      put(27'h20 + 27'(2 * w), 8'h10 + 8'(w), s);
      tick(3);
      put(27'h21 + 27'(2 * w), 8'h80 + 8'(w), s);
      expect_word(28'h20 + 28'(2 * w), 8'h10 + 8'(w), 8'h80 + 8'(w));
      if (w >= 1 && w <= 3) begin
        want_wait = (w == 3);
        total++;
        if (wait_m !== want_wait) begin
          bad++;
          $display("FAIL bp_wait_w%0d: got %b want %b", w, wait_m, want_wait);
        end
      end
      tick(3);
    end
    dl = 1'b0;
    wait_writes(6);
    repeat (6) begin
      e = exp_q.pop_front();
      total += 2;
      if (obs_m.size() == 0 || obs_s.size() == 0) begin
        bad += 2;
        $display("FAIL bp: write missing, want %h", e.addr);
      end else begin
        om = obs_m.pop_front();
        os = obs_s.pop_front();
        if (om.addr !== e.addr || om.data !== e.data_m) begin
          bad++;
          $display("FAIL bp_main: got %h/%h want %h/%h", om.addr, om.data, e.addr, e.data_m);
        end
        if (os.addr !== e.addr || os.data !== e.data_s) begin
          bad++;
          $display("FAIL bp_swap: got %h/%h want %h/%h", os.addr, os.data, e.addr, e.data_s);
        end
      end
    end
    total++;
    if (dut.r_overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_overflow_end: got %b want 0", dut.r_overflow);
    end
    tick(10);
  endtask

  task automatic test_reset_mid();
    int s, guard;
    hold = 1'b1;
    dl   = 1'b1;
    put(27'h40, 8'h01, s);
    put(27'h41, 8'h02, s);
    expect_word(28'h40, 8'h01, 8'h02);
    guard = 0;
    while (obs_m.size() < 1 && guard < 100) begin
      tick(1);
      guard++;
    end
    tick(3);
    e = exp_q.pop_front();
    total += 2;
    if (obs_m.size() == 0) begin
      bad++;
      $display("FAIL mid_first: write missing, want %h", e.addr);
    end else begin
      om = obs_m.pop_front();
      if (om.addr !== e.addr || om.data !== e.data_m) begin
        bad++;
        $display("FAIL mid_first: got %h/%h want %h/%h", om.addr, om.data, e.addr, e.data_m);
      end
    end
    // Fifteen writes since the first reset leave we_req high while waiting on the ack.
    if (req_m !== 1'b1) begin bad++; $display("FAIL mid_pre_req: got %b want 1", req_m); end
    rst_n = 1'b0;
    dl    = 1'b0;
    tick(1);
    total += 3;
    if (req_m !== 1'b0) begin bad++; $display("FAIL mid_we_req: got %b want 0", req_m); end
    if (dut.u_fifo.r_count !== '0) begin
      bad++;
      $display("FAIL mid_fifo_empty: count got %0d want 0", dut.u_fifo.r_count);
    end
    if (wait_m !== 1'b0) begin bad++; $display("FAIL mid_wait: got %b want 0", wait_m); end
    rst_n = 1'b1;
    hold  = 1'b0;
    exp_q.delete();
    obs_m.delete();
    obs_s.delete();
    tick(2);
    dl = 1'b1;
    put(27'h42, 8'h5A, s);
    put(27'h43, 8'hA5, s);
    expect_word(28'h42, 8'h5A, 8'hA5);
    dl = 1'b0;
    wait_writes(1);
    e = exp_q.pop_front();
    total += 2;
    if (obs_m.size() == 0 || obs_s.size() == 0) begin
      bad += 2;
      $display("FAIL mid_new: write missing, want %h", e.addr);
    end else begin
      om = obs_m.pop_front();
      os = obs_s.pop_front();
      if (om.addr !== e.addr || om.data !== e.data_m) begin
        bad++;
        $display("FAIL mid_new_main: got %h/%h want %h/%h", om.addr, om.data, e.addr, e.data_m);
      end
      if (os.addr !== e.addr || os.data !== e.data_s) begin
        bad++;
        $display("FAIL mid_new_swap: got %h/%h want %h/%h", os.addr, os.data, e.addr, e.data_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_pair();
    test_odd_length();
    test_orphans();
    test_backpressure();
    test_reset_mid();
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
